alu_arbiter: RTL and testbench

- Shares the single 4-bit ALU between up to NREQ control units, e.g. the credential-check sequencer and a lockout/retry timer controller.
- Each requester presents operands and an opcode with a request. The arbiter grants round-robin, drives the ALU, waits the ALU latency, then returns the registered result and status with a one-cycle done pulse.
- Sits between the control units and the ALU. It replaces the direct operand/opcode wiring.

---
 rtl/alu_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 32 +++
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter and the control units that use it.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd13;

    localparam int ST_EQ    = 3;
    localparam int ST_MATCH = 4;

    // Index width for a requester number (NREQ is limited to 2..4).
    function automatic int idx_width(input int n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx,
    output logic            any
);

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NREQ);
    endfunction

    logic found;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[wrap(int'(ptr) + i)]) begin
                found   = 1'b1;
                win_idx = wrap(int'(ptr) + i);
            end
        end
        any = found;
        win = found ? (NREQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ control units.
// Define ALU_ARB_LOCK_EN to add lock_i, letting the current winner chain back-to-back ops.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DW      = 4,
    parameter int OPW     = 4,
    parameter int SW      = 5,
    parameter int ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NREQ-1:0]     lock_i,
`endif
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ*DW-1:0]  a_i,
    input  logic [NREQ*DW-1:0]  b_i,
    input  logic [NREQ*OPW-1:0] op_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic [NREQ-1:0]     done_o,
    output logic [DW-1:0]       res_o,
    output logic [SW-1:0]       stat_o,
    output logic [DW-1:0]       alu_a_o,
    output logic [DW-1:0]       alu_b_o,
    output logic [OPW-1:0]      alu_op_o,
    input  logic [DW-1:0]       alu_r_i,
    input  logic [SW-1:0]       alu_stat_i,
    output logic                busy_o
);

    localparam int IW = idx_width(NREQ);
    localparam int LW = 3;

    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("alu_arbiter: NREQ must be in 2..4");
    end
    if (ALU_LAT < 1 || ALU_LAT > 7) begin : g_bad_lat
        $error("alu_arbiter: ALU_LAT must be in 1..7");
    end

    arb_state_e      state, state_nxt;
    logic [LW-1:0]   lat_cnt;
    logic [IW-1:0]   rr_ptr, cur_idx, load_idx;
    logic [NREQ-1:0] pick_win;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            load, capture, release_g, relock;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req     (req_i),
        .ptr     (rr_ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

`ifdef ALU_ARB_LOCK_EN
    assign relock = lock_i[cur_idx] & req_i[cur_idx];
`else
    assign relock = 1'b0;
`endif

    // req_i is a level held until done_o; gnt_o marks ALU ownership from grant through the done cycle.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_idx  = pick_idx;
        capture   = 1'b0;
        release_g = 1'b0;
        case (state)
            IDLE: if (pick_any) begin
                load      = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: if (lat_cnt == '0) begin
                capture   = 1'b1;
                state_nxt = DONE;
            end
            DONE: if (relock) begin
                load      = 1'b1;
                load_idx  = cur_idx;
                state_nxt = BUSY;
            end else begin
                release_g = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_o    <= '0;
            done_o   <= '0;
            res_o    <= '0;
            stat_o   <= '0;
            alu_a_o  <= '0;
            alu_b_o  <= '0;
            alu_op_o <= '0;
            lat_cnt  <= '0;
            rr_ptr   <= '0;
            cur_idx  <= '0;
        end else begin
            if (load) begin
                alu_a_o  <= a_i[load_idx*DW +: DW];
                alu_b_o  <= b_i[load_idx*DW +: DW];
                alu_op_o <= op_i[load_idx*OPW +: OPW];
                cur_idx  <= load_idx;
                lat_cnt  <= LW'(ALU_LAT - 1);
                done_o   <= '0;
                if (state == IDLE) gnt_o <= pick_win;
            end else if (capture) begin
                res_o  <= alu_r_i;
                stat_o <= alu_stat_i;
                done_o <= gnt_o;
            end else if (release_g) begin
                gnt_o  <= '0;
                done_o <= '0;
                rr_ptr <= (cur_idx == IW'(NREQ - 1)) ? '0 : cur_idx + 1'b1;
            end else if (state == BUSY) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a transaction-level arbitration model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int DW   = 4;
    localparam int OPW  = 4;
    localparam int SW   = 5;
    localparam int LAT  = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_i = '0;
    logic [NREQ*DW-1:0]  a_i = '0;
    logic [NREQ*DW-1:0]  b_i = '0;
    logic [NREQ*OPW-1:0] op_i = '0;
    logic [NREQ-1:0]     gnt_o, done_o;
    logic [DW-1:0]       res_o, alu_a_o, alu_b_o, alu_r_i;
    logic [SW-1:0]       stat_o, alu_stat_i;
    logic [OPW-1:0]      alu_op_o;
    logic                busy_o;
`ifdef ALU_ARB_LOCK_EN
    logic [NREQ-1:0]     lock_i = '0;
`endif

    alu_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW), .SW(SW), .ALU_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ALU_ARB_LOCK_EN
        .lock_i     (lock_i),
`endif
        .req_i      (req_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .op_i       (op_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .res_o      (res_o),
        .stat_o     (stat_o),
        .alu_a_o    (alu_a_o),
        .alu_b_o    (alu_b_o),
        .alu_op_o   (alu_op_o),
        .alu_r_i    (alu_r_i),
        .alu_stat_i (alu_stat_i),
        .busy_o     (busy_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- ALU stub and reference functions ----------------
    function automatic logic [DW-1:0] ref_res(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [OPW-1:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [SW-1:0] ref_stat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [OPW-1:0] op);
        logic [SW-1:0] st;
        st           = '0;
        st[ST_MATCH] = (a == b);
        st[ST_EQ]    = (ref_res(a, b, op) == '0);
        st[2:0]      = op[2:0];
        return st;
    endfunction

    always_comb begin
        alu_r_i    = ref_res(alu_a_o, alu_b_o, alu_op_o);
        alu_stat_i = ref_stat(alu_a_o, alu_b_o, alu_op_o);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int             idx;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic [OPW-1:0] op;
        int             due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rr_m   = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic push_exp(input int w, input int due);
        exp_t e;
        e.idx = w;
        e.a   = a_i[w*DW +: DW];
        e.b   = b_i[w*DW +: DW];
        e.op  = op_i[w*OPW +: OPW];
        e.due = due;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1) begin
            check("gnt_onehot0", int'($onehot0(gnt_o)), 1);
            if (done_o != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=%b expected none (cycle %0d)", done_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.due);
                    check("done_vec", int'(done_o), 1 << e.idx);
                    check("gnt_in_done", int'(gnt_o), 1 << e.idx);
                    check("res", int'(res_o), int'(ref_res(e.a, e.b, e.op)));
                    check("stat", int'(stat_o), int'(ref_stat(e.a, e.b, e.op)));
                    check("alu_a_held", int'(alu_a_o), int'(e.a));
                    check("alu_op_held", int'(alu_op_o), int'(e.op));
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no done expected at cycle %0d (now %0d)", exp_q[0].due, cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycle(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic set_operands();
        for (int k = 0; k < NREQ; k++) begin
            a_i[k*DW +: DW] = DW'($urandom_range(0, 15));
            b_i[k*DW +: DW] = DW'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0:       op_i[k*OPW +: OPW] = OP_ADD;
                1:       op_i[k*OPW +: OPW] = OP_SUB;
                default: op_i[k*OPW +: OPW] = OPW'($urandom_range(0, 15));
            endcase
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, int'(gnt_o), 0);
        check({tag, "_done"}, int'(done_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
    endtask

    // Holds request vector r for n consecutive operations, then drops it.
    task automatic run_held(input logic [NREQ-1:0] r, input int n, input bit rnd);
        int t0, w, first_w, last_due;
        @(negedge clk);
        if (rnd) set_operands();
        req_i   = r;
        t0      = cyc + 1;
        first_w = pick(r, rr_m);
        for (int j = 0; j < n; j++) begin
            w = pick(r, rr_m);
            push_exp(w, t0 + LAT);
            last_due = t0 + LAT;
            rr_m = (w + 1) % NREQ;
            t0 += LAT + 2;
        end
        @(negedge clk);
        check("alu_a_after_e0", int'(alu_a_o), int'(a_i[first_w*DW +: DW]));
        check("busy_after_e0", int'(busy_o), 1);
        wait_cycle(last_due);
        req_i = '0;
        @(negedge clk);
        check_idle_outputs("release");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int r, n;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_gnt", int'(gnt_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_res", int'(res_o), 0);
        check("rst_stat", int'(stat_o), 0);
        check("rst_alu_a", int'(alu_a_o), 0);
        check("rst_alu_b", int'(alu_b_o), 0);
        check("rst_alu_op", int'(alu_op_o), 0);
        check("rst_busy", int'(busy_o), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("idle_no_req");

        // directed: 3 + 1 = 4 from requester 0
        a_i[0 +: DW] = 4'd3; b_i[0 +: DW] = 4'd1; op_i[0 +: OPW] = OP_ADD;
        run_held(2'b01, 1, 1'b0);
        // directed: 5 + 11 wraps to 0, status 01000
        a_i[0 +: DW] = 4'd5; b_i[0 +: DW] = 4'd11; op_i[0 +: OPW] = OP_ADD;
        run_held(2'b01, 1, 1'b0);

        // both held: grants alternate
        run_held(2'b11, 4, 1'b1);

        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(1, 3);
            n = $urandom_range(1, 3);
            run_held(NREQ'(r), n, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // requester 1 drops its request mid-operation
        @(negedge clk);
        set_operands();
        req_i = 2'b10;
        push_exp(1, cyc + 1 + LAT);
        rr_m = 0;
        repeat (2) @(negedge clk);
        req_i = '0;
        wait_cycle(exp_q.size() > 0 ? exp_q[$].due : cyc);
        repeat (2) @(negedge clk);
        check_idle_outputs("drop");

        // async reset in BUSY with pointer parked at requester 1
        run_held(2'b01, 1, 1'b1);
        @(negedge clk);
        req_i = 2'b11;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_gnt", int'(gnt_o), 0);
        check("arst_done", int'(done_o), 0);
        check("arst_res", int'(res_o), 0);
        check("arst_stat", int'(stat_o), 0);
        check("arst_alu_a", int'(alu_a_o), 0);
        check("arst_busy", int'(busy_o), 0);
        exp_q.delete();
        @(negedge clk);
        req_i = '0;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        rr_m = 0;
        run_held(2'b11, 1, 1'b1);

`ifdef ALU_ARB_LOCK_EN
        begin
            int w, o, t0, last_due;
            @(negedge clk);
            set_operands();
            req_i  = 2'b11;
            w      = pick(2'b11, rr_m);
            o      = (w + 1) % NREQ;
            lock_i = NREQ'(1 << w);
            t0     = cyc + 1;
            for (int j = 0; j < 3; j++) begin
                push_exp(w, t0 + LAT);
                last_due = t0 + LAT;
                t0 += LAT + 1;
            end
            wait_cycle(last_due);
            lock_i = '0;
            req_i  = NREQ'(1 << o);
            rr_m   = (w + 1) % NREQ;
            push_exp(o, last_due + 2 + LAT);
            rr_m   = (o + 1) % NREQ;
            wait_cycle(last_due + 2 + LAT);
            req_i = '0;
            @(negedge clk);
            check_idle_outputs("lock_release");
        end
`endif

        repeat (LAT + 4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: got no finish expected completion by 300000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
